// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit.
// Issues word-aligned fetch requests over a valid/ready channel and waits for
// the response. Each returned word goes to the decoder with its PC through a
// one-entry output register. The PC advances by 4 (wrapping) or is redirected
// by execute; in-flight fetches made stale by a redirect are dropped with a
// kill flag.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target raises a one-cycle fetch_misalign pulse and parks
// fetch until the next aligned redirect. When it is undefined, the low two bits
// of redirect_pc are ignored.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                  fetch_misalign
`endif
);

   typedef enum logic {S_REQ, S_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    kill_q, kill_d;
   logic                    pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic                    ivld_q, ivld_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
   logic                    park_q, park_d;
   logic                    go_q;

   logic                    req_vld_w;
   logic [ADDR_WIDTH-1:0]   req_addr_w;
   logic                    hs_w;
   logic                    misalign_w;
   logic [ADDR_WIDTH-1:0]   redir_pc_w;

   // The redirect target is always word aligned; the trap build also flags misaligned targets.
   assign redir_pc_w = redirect_pc & ~ADDR_WIDTH'(3);
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign_w = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign misalign_w = 1'b0;
`endif

   // A raised request holds its address until accepted; fresh requests need an empty output register.
   assign req_vld_w  = go_q && (state_q == S_REQ) && (pend_q || (!ivld_q && !park_q));
   assign req_addr_w = pend_q ? paddr_q : pc_q;
   assign hs_w       = req_vld_w && imem_req_ready;

   assign imem_req_valid = req_vld_w;
   assign imem_req_addr  = req_addr_w;
   assign instr_valid    = ivld_q;
   assign instr          = instr_q;
   assign instr_pc       = ipc_q;

   // Next-state: request bookkeeping, response capture, output drain, then redirect override.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      pend_d  = pend_q;
      paddr_d = paddr_q;
      ivld_d  = ivld_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      park_d  = park_q;

      if (req_vld_w && !imem_req_ready) begin
         pend_d  = 1'b1;
         paddr_d = req_addr_w;
      end else if (hs_w) begin
         pend_d  = 1'b0;
      end

      if (ivld_q && instr_ready) begin
         ivld_d = 1'b0;
      end

      case (state_q)
         S_REQ: begin
            if (hs_w) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = S_REQ;
               if (kill_q) begin
                  kill_d = 1'b0;
               end else begin
                  ivld_d  = 1'b1;
                  instr_d = imem_rsp_data;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + ADDR_WIDTH'(4);
               end
            end
         end
         default: state_d = S_REQ;
      endcase

      if (redirect_valid) begin
         ivld_d  = 1'b0;
         instr_d = instr_q;
         ipc_d   = ipc_q;
         // Anything that is or will be in flight after this cycle must be discarded.
         if ((state_q == S_REQ && req_vld_w) || (state_q == S_WAIT && !imem_rsp_valid)) begin
            kill_d = 1'b1;
         end
         if (misalign_w) begin
            pc_d   = pc_q;
            park_d = 1'b1;
         end else begin
            pc_d   = redir_pc_w;
            park_d = 1'b0;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         pend_q  <= 1'b0;
         paddr_q <= '0;
         ivld_q  <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         park_q  <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         pend_q  <= pend_d;
         paddr_q <= paddr_d;
         ivld_q  <= ivld_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         park_q  <= park_d;
         go_q    <= 1'b1;
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic mis_q;

   // One-cycle registered pulse for each misaligned redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= misalign_w;
      end
   end

   assign fetch_misalign = mis_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table, hand-written redirect/wrap sequences
// and a randomized run against a stream-level reference model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
   logic        o_mis;
`endif

   instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: memory with one outstanding response, and the
   // expected PC of the next instruction the decoder should accept.
   int          cyc = 0;
   logic        m_pend = 1'b0;
   int          m_due = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] exp_pc = 32'h0;
   int          consumed = 0;
   int          cur_lat = 1;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        prev_iv_hold = 1'b0;
   logic [31:0] prev_i = '0;
   logic [31:0] prev_ipc = '0;

   logic        o_rv, o_iv;
   logic [31:0] o_addr, o_i, o_ipc;

   typedef struct {
      logic        rdy;
      logic        irdy;
      logic        rv;
      logic [31:0] rpc;
      int          lat;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(input logic rdy, input logic irdy, input logic rv,
                               input logic [31:0] rpc, input int lat, input logic erv,
                               input logic [31:0] ea, input logic eiv, input logic [31:0] eipc);
      vec_t v;
      v.rdy = rdy; v.irdy = irdy; v.rv = rv; v.rpc = rpc; v.lat = lat;
      v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_ipc = eipc;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: sample registered/state outputs, drive inputs, run the model.
   task automatic step(input logic rdy, input logic irdy, input logic rv, input logic [31:0] rpc);
      logic rsp_now;
      @(negedge clk);
      cyc++;
      o_rv = imem_req_valid; o_addr = imem_req_addr;
      o_iv = instr_valid; o_i = instr; o_ipc = instr_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
      o_mis = fetch_misalign;
`endif
      if (prev_hold) begin
         check("req_hold_valid", 32'(o_rv), 32'd1);
         check("req_hold_addr", o_addr, prev_addr);
      end
      if (prev_iv_hold) begin
         check("out_hold_valid", 32'(o_iv), 32'd1);
         check("out_hold_pc", o_ipc, prev_ipc);
         check("out_hold_instr", o_i, prev_i);
      end
      rsp_now = m_pend && (m_due == cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? memf(m_addr) : $urandom;
      if (rsp_now) m_pend = 1'b0;
      imem_req_ready = rdy; instr_ready = irdy; redirect_valid = rv; redirect_pc = rpc;
      if (o_iv && irdy && !rv) begin
         check("consume_pc", o_ipc, exp_pc);
         check("consume_instr", o_i, memf(o_ipc));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      if (rv) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
         if (rpc[1:0] == 2'b00) exp_pc = rpc;
`else
         exp_pc = rpc & ~32'h3;
`endif
      end
      if (o_rv) begin
         check("req_exclusive", 32'({o_iv, m_pend, rsp_now, o_addr[1:0]}), 32'd0);
         if (rdy) begin
            m_pend = 1'b1;
            m_addr = o_addr;
            m_due  = cyc + ((cur_lat > 0) ? cur_lat : int'($urandom_range(1, 3)));
         end
      end
      prev_hold = o_rv && !rdy; prev_addr = o_addr;
      prev_iv_hold = o_iv && !irdy && !rv; prev_i = o_i; prev_ipc = o_ipc;
   endtask

   // Step with ready=1 until a request is presented, then compare its address.
   task automatic wait_accept(input string nm, input logic [31:0] ea);
      bit seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         if (o_rv) begin
            seen = 1'b1;
            check(nm, o_addr, ea);
         end
      end
      if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] a_old;
      bit seen;
      int base;
      logic [31:0] rpc;

      // Directed table: fetches of 0x0/0x4/0x8, redirect to 0x100 while waiting
      // for 0x8 (2-cycle latency), then decoder stall for 10 cycles.
      tbl.push_back(mk(1, 1, 0, 0,      1, 1, 32'h000, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       1, 32'h000));
      tbl.push_back(mk(1, 1, 0, 0,      1, 1, 32'h004, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       1, 32'h004));
      tbl.push_back(mk(1, 1, 0, 0,      2, 1, 32'h008, 0, 0));
      tbl.push_back(mk(1, 1, 1, 32'h100, 1, 0, 0,      0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 1, 32'h100, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       0, 0));
      for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 32'h100));
      tbl.push_back(mk(1, 1, 0, 0,      1, 0, 0,       1, 32'h100));
      tbl.push_back(mk(1, 1, 0, 0,      1, 1, 32'h104, 0, 0));

      repeat (3) @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cur_lat = tbl[i].lat;
         step(tbl[i].rdy, tbl[i].irdy, tbl[i].rv, tbl[i].rpc);
         check($sformatf("tbl%0d_req_valid", i), 32'(o_rv), 32'(tbl[i].e_rv));
         if (tbl[i].e_rv) check($sformatf("tbl%0d_req_addr", i), o_addr, tbl[i].e_addr);
         check($sformatf("tbl%0d_instr_valid", i), 32'(o_iv), 32'(tbl[i].e_iv));
         if (tbl[i].e_iv) begin
            check($sformatf("tbl%0d_instr_pc", i), o_ipc, tbl[i].e_ipc);
            check($sformatf("tbl%0d_instr", i), o_i, memf(tbl[i].e_ipc));
         end
      end

      // Stalled request with a redirect to 0x200 on the second stalled cycle.
      cur_lat = 1;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         seen = o_rv;
      end
      if (!seen) check("stall_seek_timeout", 32'd0, 32'd1);
      a_old = o_addr;
      check("stall_addr", a_old, 32'h108);
      step(1'b0, 1'b1, 1'b1, 32'h200);
      check("stall_redir_addr", o_addr, a_old);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         check("stall_held_addr", o_addr, a_old);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_accept_addr", o_addr, a_old);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_drop_noreq", 32'({o_rv, o_iv}), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_next_valid", 32'(o_rv), 32'd1);
      check("stall_next_addr", o_addr, 32'h200);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_fetch_pc", {o_ipc[31:1], o_iv}, {32'h200 >> 1, 1'b1});

      // PC wrap at the top of the address space.
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      wait_accept("wrap_top_addr", 32'hFFFF_FFFC);
      wait_accept("wrap_zero_addr", 32'h0000_0000);

      // Redirect in the same cycle as the response: word dropped, no kill left behind.
      step(1'b1, 1'b1, 1'b1, 32'h300);
      check("rsp_redir_noreq", 32'(o_rv), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("rsp_redir_req_valid", 32'(o_rv), 32'd1);
      check("rsp_redir_req_addr", o_addr, 32'h300);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("rsp_redir_instr_valid", 32'(o_iv), 32'd1);
      check("rsp_redir_instr_pc", o_ipc, 32'h300);

`ifdef IFETCH_MISALIGN_TRAP_EN
      // Misaligned redirect parks fetch until an aligned redirect.
      step(1'b1, 1'b1, 1'b1, 32'h102);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("mis_pulse_high", 32'(o_mis), 32'd1);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         check("mis_parked_noreq", 32'({o_rv, o_mis}), 32'd0);
      end
      step(1'b1, 1'b1, 1'b1, 32'h104);
      wait_accept("mis_resume_addr", 32'h104);
`endif

      // Randomized traffic against the reference model.
      cur_lat = 0;
      base = consumed;
      for (int k = 0; k < 3000; k++) begin
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4) : $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
         rpc = rpc & ~32'h3;
`endif
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, rpc);
      end
      check("random_progress", 32'(consumed - base > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
